// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder
//
// Bit-serial adder. Two WIDTH-bit operands and a carry-in are accepted over a
// valid/ready handshake. The block then adds one bit per clock, LSB first,
// and presents the WIDTH-bit sum and the carry-out over a second valid/ready
// handshake.
//
// The full-adder bit slice is built from two half-adder cells and an OR gate.
// A registered carry closes the loop between consecutive bit slices. This
// trades latency for area compared with a ripple adder.
//
// Parameters
//   WIDTH      operand and sum width in bits, legal range 1..32
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands a, b and c_in are valid
//   in_ready   block can accept operands (IDLE and not in reset)
//   a, b       WIDTH-bit operands, sampled only on the accepting edge
//   c_in       carry-in, sampled only on the accepting edge
//   out_valid  sum and c_out (and ovf) are valid (DONE)
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit result
//   c_out      final unsigned carry
//   ovf        two's-complement overflow, present only when the macro
//              SERIAL_ADDER_OVF_EN is defined
//
// Timing
//   The accept cycle is cycle 0. RUN then occupies cycles 1..WIDTH, and
//   out_valid is high from cycle WIDTH+1 until the result handshake.
//   in_ready returns high one cycle after that handshake, so a new operation
//   is never accepted in the same cycle as a result is taken.
// ---------------------------------------------------------------------------
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   // Wide enough to hold WIDTH itself, so the counter never wraps early.
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Outputs of the half-adder cell: sum bit and carry bit.
   typedef struct packed {
      logic s;
      logic c;
   } ha_t;

   function automatic ha_t half_add(input logic x, input logic y);
      ha_t r;
      r.s = x ^ y;
      r.c = x & y;
      return r;
   endfunction

   state_t           state;
   state_t           state_nxt;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] sum_sh;
   logic [CNT_W-1:0] cnt;
   logic             carry;
   logic             c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   logic             accept;
   logic             last_bit;
   ha_t              ha_lo;
   ha_t              ha_hi;
   logic             bit_s;
   logic             carry_nxt;

   // ------------------------------------------------------------------------
   // Full-adder bit slice. The first half adder combines the operand bits.
   // The second half adder folds in the registered carry. The carry-out is
   // high when either half adder produced a carry.
   // ------------------------------------------------------------------------
   always_comb begin
      ha_lo     = half_add(a_sh[0], b_sh[0]);
      ha_hi     = half_add(ha_lo.s, carry);
      bit_s     = ha_hi.s;
      carry_nxt = ha_lo.c | ha_hi.c;
   end

   assign accept   = in_valid & in_ready;
   assign last_bit = (cnt == CNT_W'(WIDTH - 1));

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples pre-edge values, whatever the order of the statements.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   // NOTE: state_nxt is given a default before the case statement. This
   // prevents a latch if a branch is left without an assignment.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept)    state_nxt = RUN;
         RUN:  if (last_bit)  state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   // in_ready is masked by rst. This keeps it low during reset, even though
   // the state register only settles on the next edge.
   always_comb begin
      in_ready  = (state == IDLE) && !rst;
      out_valid = (state == DONE);
   end

   // ------------------------------------------------------------------------
   // Datapath: operand shifters, sum shifter, bit counter, carry, results
   // ------------------------------------------------------------------------
   // NOTE: the shift registers are cleared by reset along with the control
   // state. After an aborted operation, none of the old operand or partial
   // sum is visible on the outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh    <= '0;
         b_sh    <= '0;
         sum_sh  <= '0;
         cnt     <= '0;
         carry   <= 1'b0;
         c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  carry   <= c_in;
                  sum_sh  <= '0;
                  cnt     <= '0;
                  c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                  ovf_q   <= 1'b0;
`endif
               end
            end

            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               // The new bit enters at the MSB. After WIDTH shifts, the LSB
               // result has reached bit 0. This form also works for WIDTH = 1.
               sum_sh <= (sum_sh >> 1) | (WIDTH'(bit_s) << (WIDTH - 1));
               cnt    <= cnt + CNT_W'(1);
               carry  <= carry_nxt;
               if (last_bit) begin
                  c_out_q <= carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                  // While the MSB is processed, carry holds the carry into
                  // the MSB and carry_nxt holds the carry out of it.
                  ovf_q   <= carry ^ carry_nxt;
`endif
               end
            end

            // In DONE the result is frozen, so back-pressure can last
            // indefinitely.
            DONE: ;

            default: ;
         endcase
      end
   end

   assign sum   = sum_sh;
   assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder
//
// Directed testbench for serial_adder. It uses two instances:
//   dut8  WIDTH=8: basic add, carry propagation, back-pressure, mid-operation
//         reset, and the overflow vectors when SERIAL_ADDER_OVF_EN is defined
//   dut2  WIDTH=2: all 32 combinations of a, b and c_in, run back to back
//
// Inputs are driven and outputs sampled on the falling edge of clk.
// ---------------------------------------------------------------------------
module tb_serial_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // WIDTH=8 instance
   logic       iv8, ir8, ov8, or8, ci8, co8;
   logic [7:0] a8, b8, s8;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf8;
`endif

   // WIDTH=2 instance
   logic       iv2, ir2, ov2, or2, ci2, co2;
   logic [1:0] a2, b2, s2;

   int n_checks = 0;
   int n_fail   = 0;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv8),
      .in_ready  (ir8),
      .a         (a8),
      .b         (b8),
      .c_in      (ci8),
      .out_valid (ov8),
      .out_ready (or8),
      .sum       (s8),
      .c_out     (co8)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf       (ovf8)
`endif
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv2),
      .in_ready  (ir2),
      .a         (a2),
      .b         (b2),
      .c_in      (ci2),
      .out_valid (ov2),
      .out_ready (or2),
      .sum       (s2),
      .c_out     (co2)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called on a falling edge. Presents the operands and returns on the
   // falling edge of the accept cycle, where in_ready is high.
   task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic ci);
      a8  = a;
      b8  = b;
      ci8 = ci;
      iv8 = 1'b1;
      for (int i = 0; i < 50 && !ir8; i++) @(negedge clk);
   endtask

   // Waits for out_valid and counts edges from the accept cycle. Meanwhile
   // the operand inputs are scrambled, because they must be ignored during
   // RUN. When rel is 1, the result is then taken with a one-cycle
   // out_ready pulse.
   task automatic collect8(input string tag, input logic [7:0] es, input logic eco,
                           input logic eovf, input logic rel);
      int lat;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         iv8 = 1'b0;
         a8  = a8 ^ 8'hC3;
         b8  = ~b8;
         ci8 = ~ci8;
      end while (!ov8 && lat < 60);
      check({tag, "_lat"},   lat, 9);
      check({tag, "_sum"},   s8,  es);
      check({tag, "_c_out"}, co8, eco);
      check({tag, "_ready"}, ir8, 0);
`ifdef SERIAL_ADDER_OVF_EN
      check({tag, "_ovf"},   ovf8, eovf);
`else
      if (eovf === 1'bx) $display("unexpected x on expected ovf for %s", tag);
`endif
      if (rel) begin
         or8 = 1'b1;
         @(negedge clk);
         or8 = 1'b0;
         check({tag, "_valid_drop"}, ov8, 0);
      end
   endtask

   initial begin
      logic seen;
      int   lat;
      int   k;
      logic [2:0] exp3;

      rst = 1'b1;
      iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
      iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; ci2 = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", ir8, 0);
      check("rst_out_valid", ov8, 0);
      check("rst_sum", s8, 0);
      check("rst_c_out", co8, 0);
      check("rst_in_ready2", ir2, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", ir8, 1);

      // Basic add: 0x5A + 0x33 = 0x8D, signed overflow
      accept8(8'h5A, 8'h33, 1'b0);
      collect8("basic", 8'h8D, 1'b0, 1'b1, 1'b1);

      // Carry propagation
      @(negedge clk);
      accept8(8'hFF, 8'h01, 1'b0);
      collect8("carry1", 8'h00, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      accept8(8'hFF, 8'hFF, 1'b1);
      collect8("carry2", 8'hFF, 1'b1, 1'b0, 1'b1);

      // Back-pressure: 0x12 + 0x34 held for 5 cycles while in_valid is high
      @(negedge clk);
      accept8(8'h12, 8'h34, 1'b0);
      collect8("bp", 8'h46, 1'b0, 1'b0, 1'b0);
      a8 = 8'h01; b8 = 8'h02; ci8 = 1'b0; iv8 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold_sum", s8, 8'h46);
         check("bp_hold_valid", ov8, 1);
         check("bp_hold_ready", ir8, 0);
      end
      or8 = 1'b1;
      @(negedge clk);
      or8 = 1'b0;
      check("bp_ready_after", ir8, 1);
      check("bp_valid_after", ov8, 0);
      // This falling edge is in the accept cycle for 0x01 + 0x02.
      collect8("bp_next", 8'h03, 1'b0, 1'b0, 1'b1);

      // Reset mid-operation: 0xAA + 0x55 is aborted
      @(negedge clk);
      accept8(8'hAA, 8'h55, 1'b0);
      @(negedge clk);
      iv8 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_ready_in_rst", ir8, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("abort_ready_after", ir8, 1);
      check("abort_sum_zero", s8, 0);
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         seen = seen | ov8;
      end
      check("abort_no_valid", seen, 0);
      accept8(8'h01, 8'h01, 1'b0);
      collect8("after_abort", 8'h02, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_OVF_EN
      @(negedge clk);
      accept8(8'h7F, 8'h01, 1'b0);
      collect8("ovf_pos", 8'h80, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      accept8(8'h80, 8'h80, 1'b0);
      collect8("ovf_neg", 8'h00, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      accept8(8'hFF, 8'h01, 1'b0);
      collect8("ovf_none", 8'h00, 1'b1, 1'b0, 1'b1);
`endif

      // Exhaustive WIDTH=2, back to back, with out_ready held high
      @(negedge clk);
      for (k = 0; k < 32; k++) begin
         a2  = k[1:0];
         b2  = k[3:2];
         ci2 = k[4];
         iv2 = 1'b1;
         for (int i = 0; i < 20 && !ir2; i++) @(negedge clk);
         lat = 0;
         do begin
            @(negedge clk);
            lat++;
            iv2 = 1'b0;
         end while (!ov2 && lat < 20);
         exp3 = 3'((k & 3) + ((k >> 2) & 3) + (k >> 4));
         check($sformatf("exh_%0d_lat", k), lat, 3);
         check($sformatf("exh_%0d_res", k), {co2, s2}, exp3);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
